// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK receive chain: oversampling constants,
// default sample width and the phase-selector state encoding.
package qpsk_pkg;

  localparam int OS          = 4;
  localparam int NB_PHASE    = 2;
  localparam int NB_DATA_DEF = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_COMPARE,
    ST_LOCKED,
    ST_MANUAL
  } state_t;

endpackage

// File: rtl/abs_sat.sv
// Combinational saturating absolute value of a signed sample.
// The most negative input maps to the largest positive magnitude.
module abs_sat #(
  parameter int NB_DATA = 19
) (
  input  logic signed [NB_DATA-1:0] x,
  output logic        [NB_DATA-2:0] y
);

  always_comb begin
    if (x == {1'b1, {(NB_DATA-1){1'b0}}})
      y = '1;
    else if (x[NB_DATA-1])
      y = (NB_DATA-1)'(-x);
    else
      y = (NB_DATA-1)'(x);
  end

endmodule

// File: rtl/phase_sync_ctrl.sv
// Downsampling-phase selector: accumulates |sample| per phase over a window
// of symbols and locks onto the phase with the most energy.
module phase_sync_ctrl
  import qpsk_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int LOG2_WIN = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic signed [NB_DATA-1:0] i_data,
  input  logic                      i_start,
  input  logic                      i_manual,
  input  logic [NB_PHASE-1:0]       i_sw,
  output logic [NB_PHASE-1:0]       o_phase,
  output logic                      o_locked,
  output logic                      o_busy
);

  localparam int NB_ACC = NB_DATA + LOG2_WIN;

  state_t                state, state_d;
  logic [NB_ACC-1:0]     acc [OS];
  logic [NB_PHASE-1:0]   phase_cnt;
  logic [LOG2_WIN-1:0]   sym_cnt;
  logic                  win_done;
  logic [NB_PHASE-1:0]   cmp_k;
  logic [NB_PHASE-1:0]   best, best_d;
  logic [NB_DATA-2:0]    abs_val;

  logic clr, acc_en, cmp_step, lock_load, man_load;

  abs_sat #(.NB_DATA(NB_DATA)) u_abs_sat (
    .x (i_data),
    .y (abs_val)
  );

  // Running argmax; strict compare keeps the lowest index on ties.
  always_comb begin
    best_d = best;
    if (cmp_k == '0)
      best_d = '0;
    else if (acc[cmp_k] > acc[best])
      best_d = cmp_k;
  end

  // NOTE: state register uses non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    clr       = 1'b0;
    acc_en    = 1'b0;
    cmp_step  = 1'b0;
    lock_load = 1'b0;
    man_load  = 1'b0;
    if (i_manual) begin
      state_d  = ST_MANUAL;
      clr      = 1'b1;
      man_load = 1'b1;
    end else if (i_start) begin
      state_d = ST_ACCUM;
      clr     = 1'b1;
    end else begin
      case (state)
        ST_MANUAL: state_d = ST_IDLE;
        ST_ACCUM: begin
          if (win_done)    state_d = ST_COMPARE;
          else if (enable) acc_en  = 1'b1;
        end
        ST_COMPARE: begin
          cmp_step = 1'b1;
          if (cmp_k == NB_PHASE'(OS - 1)) begin
            state_d   = ST_LOCKED;
            lock_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the four accumulators are plain registers, not a RAM, so they are
  // reset and cleared in parallel like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < OS; p++) acc[p] <= '0;
      phase_cnt <= '0;
      sym_cnt   <= '0;
      win_done  <= 1'b0;
      cmp_k     <= '0;
      best      <= '0;
      o_phase   <= '0;
      o_locked  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_busy <= (state_d == ST_ACCUM) || (state_d == ST_COMPARE);
      if (clr) begin
        for (int p = 0; p < OS; p++) acc[p] <= '0;
        phase_cnt <= '0;
        sym_cnt   <= '0;
        win_done  <= 1'b0;
        cmp_k     <= '0;
      end else begin
        if (acc_en) begin
          acc[phase_cnt] <= acc[phase_cnt] + NB_ACC'(abs_val);
          phase_cnt      <= phase_cnt + 1'b1;
          if (phase_cnt == NB_PHASE'(OS - 1)) begin
            sym_cnt <= sym_cnt + 1'b1;
            if (sym_cnt == '1) win_done <= 1'b1;
          end
        end
        if (cmp_step) begin
          best  <= best_d;
          cmp_k <= cmp_k + 1'b1;
        end
      end
      if (man_load) begin
        o_phase  <= i_sw;
        o_locked <= 1'b0;
      end else if (lock_load) begin
        o_phase  <= best_d;
        o_locked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_sync_ctrl.sv
// Self-checking bench for phase_sync_ctrl with a 4-symbol window; expected
// phases are queued when a window is driven and popped when the lock lands.
module tb_phase_sync_ctrl;
  import qpsk_pkg::*;

  localparam int NB_DATA  = 19;
  localparam int LOG2_WIN = 2;
  localparam int NWIN     = 4 * (1 << LOG2_WIN);

  logic                      clk = 1'b0;
  logic                      rst, enable, i_start, i_manual;
  logic signed [NB_DATA-1:0] i_data;
  logic [1:0]                i_sw, o_phase;
  logic                      o_locked, o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  phase_sync_ctrl #(.NB_DATA(NB_DATA), .LOG2_WIN(LOG2_WIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .i_data   (i_data),
    .i_start  (i_start),
    .i_manual (i_manual),
    .i_sw     (i_sw),
    .o_phase  (o_phase),
    .o_locked (o_locked),
    .o_busy   (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int abs_model(input int v);
    if (v == -(1 << 18)) return (1 << 18) - 1;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int model_phase(input int vals[4]);
    int best = 0;
    for (int p = 1; p < 4; p++)
      if (abs_model(vals[p]) > abs_model(vals[best])) best = p;
    return best;
  endfunction

  task automatic drive_enables(input int vals[4], input int n, input bit gap);
    for (int s = 0; s < n; s++) begin
      if (gap) begin
        enable = 1'b0;
        i_data = NB_DATA'(99999);
        @(negedge clk);
      end
      enable = 1'b1;
      i_data = NB_DATA'(vals[s % 4]);
      @(negedge clk);
    end
    enable = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Full window; the lock must appear exactly 5 clk after the last enable.
  task automatic run_window(input int vals[4], input bit gap, input string tag);
    logic [1:0] prev_phase;
    logic       prev_locked;
    prev_phase  = o_phase;
    prev_locked = o_locked;
    start();
    exp_q.push_back(model_phase(vals));
    drive_enables(vals, NWIN, gap);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check({tag, "_busy_pending"}, 32'(o_busy), 32'd1);
    end
    check({tag, "_locked_held"}, 32'(o_locked), 32'(prev_locked));
    check({tag, "_phase_held"}, 32'(o_phase), 32'(prev_phase));
    @(negedge clk);
    check({tag, "_busy_done"}, 32'(o_busy), 32'd0);
    check({tag, "_locked"}, 32'(o_locked), 32'd1);
    check({tag, "_phase"}, 32'(o_phase), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int peak2[4], neg1[4], tie[4], peak3[4], peak1[4], peak0[4];
    peak2 = '{100, 100, 1000, 100};
    neg1  = '{500, -262144, 500, 500};
    tie   = '{300, 300, 300, 300};
    peak3 = '{10, 10, 10, 2000};
    peak1 = '{20, 700, 20, 20};
    peak0 = '{900, 50, 50, 50};

    rst = 1'b1; enable = 1'b0; i_data = '0; i_start = 1'b0;
    i_manual = 1'b0; i_sw = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_phase", 32'(o_phase), 32'd0);
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;

    drive_enables(peak2, 100, 1'b0);
    @(negedge clk);
    check("idle_phase", 32'(o_phase), 32'd0);
    check("idle_locked", 32'(o_locked), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);

    run_window(peak2, 1'b0, "clean_peak");
    check("clean_acc2", 32'(dut.acc[2]), 32'(4 * 1000));

    run_window(neg1, 1'b0, "neg_sat");
    check("neg_acc1", 32'(dut.acc[1]), 32'(4 * 262143));

    run_window(tie, 1'b1, "tie_gaps");

    start();
    drive_enables(peak3, 5, 1'b0);
    i_manual = 1'b1;
    i_sw     = 2'd3;
    @(negedge clk);
    check("man_phase", 32'(o_phase), 32'd3);
    check("man_locked", 32'(o_locked), 32'd0);
    check("man_busy", 32'(o_busy), 32'd0);
    i_manual = 1'b0;
    i_sw     = 2'd1;
    @(negedge clk);
    check("man_exit_phase", 32'(o_phase), 32'd3);
    check("man_exit_locked", 32'(o_locked), 32'd0);
    run_window(peak1, 1'b0, "after_manual");

    start();
    drive_enables(peak3, 7, 1'b0);
    check("restart_busy", 32'(o_busy), 32'd1);
    check("restart_locked", 32'(o_locked), 32'd1);
    check("restart_phase", 32'(o_phase), 32'd1);
    run_window(peak0, 1'b0, "restart");

    start();
    drive_enables(peak2, 10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_phase", 32'(o_phase), 32'd0);
    check("midrst_locked", 32'(o_locked), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_acc2", 32'(dut.acc[2]), 32'd0);
    drive_enables(peak2, 20, 1'b0);
    repeat (6) @(negedge clk);
    check("midrst_nolock", 32'(o_locked), 32'd0);
    check("midrst_idle", 32'(o_busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sync_ctrl.md
Name: phase_sync_ctrl

Overview:
- Automatic downsampling-phase selector for the QPSK receive chain at 4x oversampling.
- Accumulates |matched-filter output| separately for each of the 4 sample phases over a window of symbols, then picks the phase with maximum energy.
- Drives the 2-bit phase-select input of the receiver's decision stage.
- Manual override passes the board switches straight through.

Parameters:
- NB_DATA, 19, width of signed filter-output sample i_data.
- LOG2_WIN, 10, log2 of window length in symbols (window = 2^LOG2_WIN symbols = 4*2^LOG2_WIN samples).
- NB_ACC (localparam), NB_DATA+LOG2_WIN, per-phase accumulator width; no overflow possible by construction.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  sample strobe; one filter sample per enable-high cycle.
- i_data  in  NB_DATA  signed filter output, valid when enable=1.
- i_start  in  1  single-cycle pulse: begin/restart acquisition.
- i_manual  in  1  level: 1 = override with i_sw.
- i_sw  in  2  manual phase value.
- o_phase  out  2  selected downsampling phase (0..3).
- o_locked  out  1  1 = o_phase is the result of a completed acquisition.
- o_busy  out  1  1 while in ACCUM or COMPARE.

Behaviour:
- Reset: state IDLE, o_phase=0, o_locked=0, o_busy=0, all 4 accumulators=0, phase counter=0, symbol counter=0.
- States: IDLE, ACCUM, COMPARE, LOCKED, MANUAL.
- Priority each cycle: rst > i_manual > i_start > normal operation.
- MANUAL:
  - Entered from any state when i_manual=1.
  - o_phase <= i_sw every cycle (1-cycle latency); o_locked=0; o_busy=0; accumulators cleared.
  - On i_manual falling, go to IDLE; o_phase holds its last value.
- IDLE: outputs held. i_start moves to ACCUM, clearing accumulators and both counters.
- ACCUM:
  - o_busy=1.
  - On each enable-high cycle: acc[phase_cnt] += abs_sat(i_data), then phase_cnt increments mod 4.
  - On the 3->0 wrap, sym_cnt increments.
  - Enable-low cycles change nothing.
  - The first enable after i_start is phase 0.
  - When the enable that completes symbol 2^LOG2_WIN-1 (phase 3) occurs, go to COMPARE on the next cycle.
- abs_sat: |x| for x>-2^(NB_DATA-1); the most negative value maps to 2^(NB_DATA-1)-1. Result is unsigned, NB_DATA-1 bits.
- COMPARE:
  - Sequential, 4 cycles, index k=0..3.
  - best initialises to k=0; for k=1..3, replace best only if acc[k] > acc[best] (strict), so ties resolve to the lowest index.
  - enable is ignored in this state.
  - After k=3, go to LOCKED.
- LOCKED:
  - Registered on entry: o_phase=best, o_locked=1, o_busy=0.
  - Total latency from the final window enable to o_locked=1 is 5 clk.
  - i_start re-acquires: o_locked stays 1 and o_phase holds until the new result, then both update together.
- i_start during ACCUM or COMPARE: restart ACCUM (accumulators and counters cleared). o_locked and o_phase keep their prior values.
- rst mid-operation: immediate return to reset values on the next edge.

Decomposition:
- Shared package (qpsk_pkg):
  - State enum encoding.
  - OS=4 and NB_PHASE=2 constants.
  - Default NB_DATA=19, reused by the receiver filter.
- One sub-module, abs_sat: combinational saturating absolute value, parameterised by NB_DATA. Reused later for the AGC.

Test Plan (LOG2_WIN=2: 4 symbols, 16 samples):
1. Reset: assert rst for 2 clk -> o_phase=0, o_locked=0, o_busy=0. No i_start -> outputs unchanged after 100 enables.
2. Clean peak: i_start, then 16 enables with samples at phase 2 = +1000 and others = +100 -> o_busy falls and o_locked=1, o_phase=2 exactly 5 clk after the 16th enable; internal acc[2]=4000.
3. Negative peak and saturation: phase 1 = -262144 (-2^18), others = +500 -> phase-1 abs contributes 262143 per symbol; o_phase=1.
4. Tie, with gaps: all samples = 300, enable toggled 1/0 every cycle -> completes after 16 enable-high cycles (32 clk); o_phase=0.
5. Manual override: during ACCUM, set i_manual=1, i_sw=3 -> next clk o_phase=3, o_locked=0, o_busy=0. Deassert -> IDLE with o_phase=3. New i_start with peak at phase 1 -> o_phase=1, o_locked=1.
6. Restart and reset mid-window:
   - i_start after 7 enables of a phase-3 peak, then 16 enables of a phase-0 peak -> o_phase=0 (first partial data discarded).
   - rst at enable 10 of a window -> all reset values, no lock.
